// File: rtl/gnrl_sync_fifo_pkg.sv
// gnrl_sync_fifo_pkg: width helpers shared by the FIFO and its pointer sub-module
package gnrl_sync_fifo_pkg;
  function automatic int cw_of(input int dp);
    return $clog2(dp + 1);
  endfunction
  function automatic int pw_of(input int dp);
    return dp > 1 ? $clog2(dp) : 1;
  endfunction
endpackage

// File: rtl/gnrl_fifo_ptr.sv
// gnrl_fifo_ptr: wrapping 0..DP-1 pointer with increment enable and sync clear
module gnrl_fifo_ptr
  import gnrl_sync_fifo_pkg::*;
#(
  parameter int DP = 4,
  localparam int PW = pw_of(DP)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge clk)
    ptr <= clr ? '0 : !inc ? ptr : ptr == PW'(DP - 1) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/gnrl_sync_fifo.sv
// gnrl_sync_fifo: valid/ready synchronous FIFO, any depth 1..256, zero-masked head output
module gnrl_sync_fifo
  import gnrl_sync_fifo_pkg::*;
#(
  parameter int DW = 32,
  parameter int DP = 4,
  localparam int CW = cw_of(DP),
  localparam int PW = pw_of(DP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [CW-1:0] cnt
);
  logic [DW-1:0] mem [DP];
  logic [PW-1:0] rptr, wptr;
  logic          push, pop;
  assign i_rdy = cnt != CW'(DP);
  assign o_vld = cnt != '0;
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;
  assign o_dat = o_vld ? mem[rptr] : '0;
  gnrl_fifo_ptr #(.DP(DP)) u_wptr (.clk(clk), .clr(rst), .inc(push), .ptr(wptr));
  gnrl_fifo_ptr #(.DP(DP)) u_rptr (.clk(clk), .clr(rst), .inc(pop), .ptr(rptr));
  always_ff @(posedge clk)
    cnt <= rst ? '0 : cnt + CW'(push) - CW'(pop);
  // storage is deliberately left out of reset; o_dat masking hides stale entries
  always_ff @(posedge clk)
    if (push && !rst) mem[wptr] <= i_dat;
endmodule

// File: tb/tb_gnrl_sync_fifo.sv
// tb_gnrl_sync_fifo: queue-model check of gnrl_sync_fifo (DP=4, DW=8) with directed and random traffic
module tb_gnrl_sync_fifo;
  localparam int DW = 8;
  localparam int DP = 4;
  logic          clk = 0;
  logic          rst = 0;
  logic          i_vld = 0;
  logic          i_rdy;
  logic [DW-1:0] i_dat = '0;
  logic          o_vld;
  logic          o_rdy = 0;
  logic [DW-1:0] o_dat;
  logic [2:0]    cnt;
  int checks = 0;
  int failures = 0;
  bit armed = 0;
  logic [DW-1:0] q[$];

  gnrl_sync_fifo #(.DW(DW), .DP(DP)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    i_vld = v;
    i_dat = d;
    o_rdy = r;
  endtask

  // Reference: an ordered queue bounded at DP entries; handshakes judged on the size before the edge
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      armed <= 1;
    end else if (armed) begin
      if (i_vld && q.size() < DP) begin
        q.push_back(i_dat);
        if (o_rdy && q.size() > 1) void'(q.pop_front());
      end else if (o_rdy && q.size() > 0) void'(q.pop_front());
    end
  end

  always @(negedge clk)
    if (armed) begin
      chk("cnt", 32'(cnt), 32'(q.size()));
      chk("i_rdy", 32'(i_rdy), 32'(q.size() != DP));
      chk("o_vld", 32'(o_vld), 32'(q.size() != 0));
      chk("o_dat", 32'(o_dat), q.size() != 0 ? 32'(q[0]) : 32'h0);
    end

  initial begin
    rst = 1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    rst = 0;
    chk("rst_i_rdy", 32'(i_rdy), 1);
    chk("rst_o_vld", 32'(o_vld), 0);
    chk("rst_o_dat", 32'(o_dat), 0);
    chk("rst_cnt", 32'(cnt), 0);
    drive(1, 8'h11, 0);
    drive(1, 8'h22, 0);
    drive(1, 8'h33, 0);
    drive(1, 8'h44, 0);
    drive(0, 0, 0);
    chk("full_i_rdy", 32'(i_rdy), 0);
    chk("full_cnt", 32'(cnt), 4);
    chk("full_o_vld", 32'(o_vld), 1);
    chk("full_o_dat", 32'(o_dat), 32'h11);
    drive(1, 8'h55, 1);
    drive(0, 0, 0);
    chk("popfull_cnt", 32'(cnt), 3);
    chk("popfull_i_rdy", 32'(i_rdy), 1);
    chk("popfull_o_dat", 32'(o_dat), 32'h22);
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 0, 0);
    chk("drain_cnt", 32'(cnt), 0);
    drive(1, 8'hA5, 1);
    chk("empty_o_vld", 32'(o_vld), 0);
    chk("empty_o_dat", 32'(o_dat), 0);
    drive(0, 0, 0);
    chk("empty_push_o_vld", 32'(o_vld), 1);
    chk("empty_push_o_dat", 32'(o_dat), 32'hA5);
    chk("empty_push_cnt", 32'(cnt), 1);
    drive(1, 8'hB0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'hC0 + 8'(i), 1);
      chk("stream_cnt", 32'(cnt), 2);
    end
    drive(0, 0, 0);
    chk("stream_head", 32'(o_dat), 32'hC8);
    drive(1, 8'hD0, 0);
    drive(0, 0, 0);
    chk("pre_rst_cnt", 32'(cnt), 3);
    rst = 1;
    i_vld = 1;
    i_dat = 8'hEE;
    o_rdy = 1;
    drive(0, 0, 0);
    rst = 0;
    chk("midrst_cnt", 32'(cnt), 0);
    chk("midrst_o_vld", 32'(o_vld), 0);
    chk("midrst_o_dat", 32'(o_dat), 0);
    chk("midrst_i_rdy", 32'(i_rdy), 1);
    drive(1, 8'h7E, 0);
    drive(0, 0, 0);
    chk("after_rst_head", 32'(o_dat), 32'h7E);
    chk("after_rst_cnt", 32'(cnt), 1);
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    drive(0, 0, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gnrl_sync_fifo.md
GNRL_SYNC_FIFO -- requirements
Module: gnrl_sync_fifo

Interface
REQ-001 Parameter DW, default 32: width of each data entry in bits.
REQ-002 Parameter DP, default 4: depth in entries; legal range 1..256; need not be a power of two.
REQ-003 Port clk  input  1  the block's single clock; every flop is updated on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port i_vld  input  1  the writer is offering a data word.
REQ-006 Port i_rdy  output  1  the FIFO can accept a word this cycle.
REQ-007 Port i_dat  input  DW  write data.
REQ-008 Port o_vld  output  1  the FIFO holds at least one word.
REQ-009 Port o_rdy  input  1  the reader consumes the head word this cycle.
REQ-010 Port o_dat  output  DW  head-of-queue data.
REQ-011 Port cnt  output  CW  number of words held; CW = clog2(DP+1).

Function
REQ-012 A push SHALL occur on a rising edge where i_vld and i_rdy are both 1; a pop SHALL occur on a rising edge where o_vld and o_rdy are both 1.
REQ-013 i_rdy SHALL equal (cnt != DP) and o_vld SHALL equal (cnt != 0), both decoded from registered state only, with no combinational path from i_vld or o_rdy.
REQ-014 o_dat SHALL present the oldest stored entry while o_vld=1, and all-zeros while o_vld=0.
REQ-015 Latency: a word pushed on edge N SHALL appear on o_dat with o_vld=1 after edge N; there is no same-cycle bypass, even when the FIFO is empty.
REQ-016 The write pointer SHALL advance on each push, and the read pointer on each pop, wrapping from DP-1 to 0.
REQ-017 cnt SHALL change as follows on each edge:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop, or when neither occurs.
REQ-018 Full (cnt=DP) boundary: i_rdy=0, so no push occurs; a pop in that cycle SHALL still complete, and i_rdy SHALL return to 1 on the next cycle.
REQ-019 Empty (cnt=0) boundary: o_rdy SHALL be ignored; a simultaneous push SHALL store the word, and cnt SHALL become 1.
REQ-020 Overflow and underflow SHALL be impossible by construction: pointer and count updates are gated by the handshake terms only.
REQ-021 With DP=1, the block SHALL behave as a single-entry half-rate buffer: i_rdy and o_vld are mutually exclusive.
REQ-022 Ordering: words SHALL leave in exactly the order they were accepted, with no loss and no duplication.

Reset
REQ-023 While rst=1 on a rising edge, rptr, wptr and cnt SHALL be cleared to 0; outputs after that edge SHALL be i_rdy=1, o_vld=0, o_dat=0 and cnt=0.
REQ-024 Storage entries SHALL NOT be reset; reset-free storage is acceptable because of the zero-masking in REQ-014.
REQ-025 Reset asserted mid-operation SHALL discard all held words within that edge; pushes and pops offered in the same cycle SHALL be ignored.

Structure
REQ-026 The shared defines include file SHALL hold the width macro used for CW; no other shared typedefs are needed.
REQ-027 One sub-module, gnrl_fifo_ptr, SHALL be used:
  - it implements a wrapping pointer with parameter DP, an increment enable and synchronous active-high clear;
  - it is instantiated twice, once for rptr and once for wptr.
REQ-028 Storage SHALL be a DP x DW register array written at wptr and read through a DP:1 mux at rptr; no RAM macro is used.

Verification (DP=4, DW=8)
REQ-029 Reset, then push 0x11, 0x22, 0x33, 0x44 with o_rdy=0 -> i_rdy falls to 0 after the 4th push, cnt=4, o_vld=1, o_dat=0x11.
REQ-030 From full, hold i_vld=1 with i_dat=0x55 and o_rdy=1 for one cycle -> 0x11 is popped, 0x55 is not accepted, cnt=3, i_rdy=1.
REQ-031 Empty, with i_vld=1, i_dat=0xA5 and o_rdy=1 on the same edge -> o_vld=0 that cycle, o_dat=0; the next cycle o_vld=1, o_dat=0xA5, cnt=1.
REQ-032 Continuous push and pop at cnt=2 for 10 cycles with an incrementing data pattern -> cnt stays 2, the output sequence is in order, and both pointers wrap past index 3 correctly.
REQ-033 Assert rst at cnt=3 with push and pop active -> on the next cycle cnt=0, o_vld=0, o_dat=0, i_rdy=1; the next push of 0x7E is read out as the first word.
REQ-034 Random i_vld/o_rdy for 10k cycles checked against a scoreboard queue -> no mismatch, and cnt always equals the scoreboard size and stays within 0..4.
